rgb_pwm_driver: RTL
===================

// Module: rgb_pwm_driver
// PURPOSE
//  Drives the physical RGB LED from the 24-bit colour word produced by the lights selector.
//  Converts each 8-bit channel into a PWM waveform (R, G, B), with duty = channel value / 255.
//  A new colour is loaded into a shadow register and only takes effect at a period boundary,
//  so there are no mid-period glitches.
// PARAMETERS
//  PRESCALE  1  clocks per PWM count step; must be >= 1. Period = 255*PRESCALE clocks.
// PORTS
//  clk         input   1   system clock, all logic on rising edge
//  rst         input   1   synchronous reset, active-high
//  light       input   24  colour word: [23:16]=R, [15:8]=G, [7:0]=B
//  load        input   1   capture light into pending register this cycle
//  pwm_r       output  1   red PWM, registered
//  pwm_g       output  1   green PWM, registered
//  pwm_b       output  1   blue PWM, registered
//  period_end  output  1   one-cycle pulse on the last cycle of each PWM period, registered
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous, active-high.
//  Reset values (rst=1 at a clock edge):
//   - pre=0, cnt=0.
//   - pending=24'hFFFFFF, active=24'hFFFFFF (white, the selector's reset colour).
//   - pwm_r/g/b=0, period_end=0.
//  Prescaler:
//   - pre counts 0..PRESCALE-1 and wraps.
//   - tick = (pre==PRESCALE-1); with PRESCALE=1, tick is 1 every cycle.
//  Step counter:
//   - cnt is 8 bits, range 0..254 (255 steps); it advances only on tick.
//   - On tick with cnt==254, cnt wraps to 0 (this is the wrap event). cnt never holds 255.
//  Period end:
//   - period_end <= tick && cnt==254, i.e. high in the cycle after the final step edge.
//  Shadow load:
//   - load=1: pending <= light. Multiple loads in one period: the last one wins.
//   - On the wrap event: active <= (load ? light : pending).
//     A load coincident with the wrap goes straight into the new period.
//  PWM compare (one-cycle latency from cnt/active):
//   - pwm_r <= (cnt < active[23:16]); likewise pwm_g uses [15:8] and pwm_b uses [7:0].
//   - Value 0: output always low. Value 255: always high (cnt<=254).
//   - Value N: high for N*PRESCALE clocks per period, starting at period start.
//  Comparison is unsigned 8-bit; no other arithmetic widths are involved.
//  load while rst=1 is ignored: reset wins over load.
//  Reset mid-period: everything returns to reset values on the next edge.
//   - After rst drops, the first period starts with cnt=0 and shows white.
//  light is sampled only when load=1; otherwise changes on light are don't-care.
// TESTING (PRESCALE=1 unless stated)
//  1. rst=1 for 2 clocks -> pwm_r/g/b=0, period_end=0. Release rst -> all three pwm high
//     from the next cycle, continuously (white); period_end pulses every 255 clocks.
//  2. load=1 with light=24'h800040 at mid-period -> outputs stay white until period_end.
//     Next period: R high 128 clocks, G low all 255, B high 64 clocks, all rising together.
//  3. load light=24'h000000 -> after the next wrap, all pwm low for the whole period,
//     with no single-cycle high glitch at the boundary.
//  4. load 24'h0A0B0C in the same cycle as the wrap -> the new period shows high counts
//     10/11/12. A second load of 24'h010203 in the same period -> next period shows 1/2/3.
//  5. Load 24'h123456 (pending) then assert rst mid-period -> outputs 0 next cycle.
//     After release, white is shown (pending discarded) and cnt restarts, so period_end
//     occurs exactly 255 clocks after the first post-reset edge.
//  6. PRESCALE=4, light=24'h02FF00 -> period_end every 1020 clocks; R high 8 clocks,
//     G high 1020, B always low.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: converts a 24-bit RGB colour word into three PWM outputs.
// New colours are captured into a pending (shadow) register and promoted to
// the active colour only at the period wrap, so a period is never glitched.
//
// Parameters:
//   PRESCALE    clocks per PWM count step (>= 1); period = 255*PRESCALE clocks
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   light       colour word: [23:16]=R, [15:8]=G, [7:0]=B
//   load        capture light into the pending register this cycle
//   pwm_r/g/b   registered PWM outputs, duty = channel / 255
//   period_end  registered one-cycle pulse on the last cycle of each period
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] light,
    input  logic        load,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        period_end
);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // A 1-bit prescaler is kept for PRESCALE=1; it simply stays at 0.
    localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned PRE_MAX  = (PRESCALE > 1) ? PRESCALE - 1 : 0;
    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(254);
    localparam rgb_t        WHITE    = 24'hFFFFFF;

    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt;
    rgb_t             pending;
    rgb_t             active;
    logic             tick_c;
    logic             wrap_c;

    assign tick_c = (pre == PRE_W'(PRE_MAX));
    assign wrap_c = tick_c && (cnt == CNT_LAST);

    // Prescaler: 0..PRESCALE-1, wrapping on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (tick_c) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Step counter: 0..254, never holds 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
        end
    end

    // Shadow colour: a load coincident with the wrap bypasses pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= WHITE;
            active  <= WHITE;
        end else begin
            if (load) begin
                pending <= rgb_t'(light);
            end
            if (wrap_c) begin
                active <= load ? rgb_t'(light) : pending;
            end
        end
    end

    // Compare stage: one cycle behind cnt/active.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_r      <= 1'b0;
            pwm_g      <= 1'b0;
            pwm_b      <= 1'b0;
            period_end <= 1'b0;
        end else begin
            pwm_r      <= (cnt < active.r);
            pwm_g      <= (cnt < active.g);
            pwm_b      <= (cnt < active.b);
            period_end <= wrap_c;
        end
    end

endmodule
